riscv_id_ex_stage: RTL

//  Decode + ID/EX pipeline register directly upstream of RISCV_ALU. Takes a fetched RV32I

---
 rtl/riscv_id_ex_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/riscv_id_ex_stage.sv
// RV32I OP/OP-IMM decoder and one-entry ID/EX register feeding the ALU.
// Optional writeback forwarding into A/B enabled by defining ID_WB_FWD_EN.
module riscv_id_ex_stage #(
    parameter int          XLEN       = 32,
    parameter logic [4:0]  RESET_CTRL = 5'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [31:0]     Inst,
    input  logic [XLEN-1:0] RS1_Data,
    input  logic [XLEN-1:0] RS2_Data,
    input  logic            Flush,
    input  logic            WB_En,
    input  logic [4:0]      WB_Rd,
    input  logic [XLEN-1:0] WB_Data,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [4:0]      ALU_Ctrl,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [XLEN-1:0] Imm,
    output logic [4:0]      Rd,
    output logic            RegWrite,
    output logic            Illegal
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'h20;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opc = Inst[6:0];
    assign f3  = Inst[14:12];
    assign f7  = Inst[31:25];
    assign rs1 = Inst[19:15];
    assign rs2 = Inst[24:20];

    logic            valid_q;
    logic [4:0]      ctrl_q,  ctrl_d;
    logic [XLEN-1:0] a_q,     a_d;
    logic [XLEN-1:0] b_q,     b_d;
    logic [XLEN-1:0] imm_q,   imm_d;
    logic [4:0]      rd_q;
    logic            rw_q,    rw_d;
    logic            ill_q,   ill_d;
    logic            legal;
    logic            load;

    assign In_Ready = !valid_q || Out_Ready;
    assign load     = In_Valid && In_Ready && !Flush;

    always_comb begin
        ctrl_d = 5'd0;
        imm_d  = '0;
        legal  = 1'b0;
        case (opc)
            OPC_OP: begin
                legal = (f7 == 7'h00) ||
                        (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
                case (f3)
                    3'b000:  ctrl_d = f7[5] ? 5'd9 : 5'd1;
                    3'b001:  ctrl_d = 5'd17;
                    3'b010:  ctrl_d = 5'd10;
                    3'b011:  ctrl_d = 5'd12;
                    3'b100:  ctrl_d = 5'd5;
                    3'b101:  ctrl_d = f7[5] ? 5'd19 : 5'd18;
                    3'b110:  ctrl_d = 5'd3;
                    default: ctrl_d = 5'd7;
                endcase
            end
            OPC_IMM: begin
                legal = 1'b1;
                imm_d = {{(XLEN-12){Inst[31]}}, Inst[31:20]};
                case (f3)
                    3'b000:  ctrl_d = 5'd2;
                    3'b010:  ctrl_d = 5'd11;
                    3'b011:  ctrl_d = 5'd13;
                    3'b100:  ctrl_d = 5'd6;
                    3'b110:  ctrl_d = 5'd4;
                    3'b111:  ctrl_d = 5'd8;
                    3'b001: begin
                        legal  = (f7 == 7'h00);
                        ctrl_d = 5'd14;
                        imm_d  = {{(XLEN-5){1'b0}}, rs2};
                    end
                    default: begin
                        legal  = (f7 == 7'h00) || (f7 == F7_ALT);
                        ctrl_d = f7[5] ? 5'd16 : 5'd15;
                        imm_d  = {{(XLEN-5){1'b0}}, rs2};
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            ctrl_d = 5'd0;
            imm_d  = '0;
        end
        ill_d = !legal;
        rw_d  = legal && (Inst[11:7] != 5'd0);
    end

    // Forwarded value is overridden by x0 forcing below.
    always_comb begin
        a_d = RS1_Data;
        b_d = RS2_Data;
`ifdef ID_WB_FWD_EN
        if (WB_En && WB_Rd != 5'd0 && WB_Rd == rs1) a_d = WB_Data;
        if (WB_En && WB_Rd != 5'd0 && WB_Rd == rs2) b_d = WB_Data;
`endif
        if (rs1 == 5'd0) a_d = '0;
        if (rs2 == 5'd0) b_d = '0;
    end

`ifndef ID_WB_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{WB_En, WB_Rd, WB_Data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= RESET_CTRL;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (Flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rd_q    <= Inst[11:7];
            rw_q    <= rw_d;
            ill_q   <= ill_d;
        end else if (Out_Ready) begin
            valid_q <= 1'b0;
        end
    end

    assign Out_Valid = valid_q;
    assign ALU_Ctrl  = ctrl_q;
    assign A         = a_q;
    assign B         = b_q;
    assign Imm       = imm_q;
    assign Rd        = rd_q;
    assign RegWrite  = rw_q;
    assign Illegal   = ill_q;

endmodule
